// File: rtl/oka_trunc_div_pkg.sv
// ============================================================================
//  oka_pkg : shared types, defaults and GF(2) helpers for oka_trunc_div
//  Rev 1.0
// ============================================================================
`default_nettype none

package oka_pkg;

  localparam int W_DEF = 8;
  localparam int CNT_W = $clog2(W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Carry-less product of a and b, keeping only the low w bits.
  function automatic logic [63:0] clmul_trunc(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input int          w);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w && a[i]) p = p ^ (b << i);
    end
    for (int i = 0; i < 64; i++) begin
      if (i >= w) p[i] = 1'b0;
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/oka_trunc_div_if.sv
// ============================================================================
//  oka_trunc_div_if : valid/ready bus for the truncated GF(2) divider
//  Rev 1.0
// ============================================================================
`default_nettype none

interface oka_trunc_div_if #(
  parameter int W = oka_pkg::W_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic         err;

  modport master (
    output in_valid, y, b, out_ready,
    input  in_ready, out_valid, a, err
  );

  modport slave (
    input  in_valid, y, b, out_ready,
    output in_ready, out_valid, a, err
  );
endinterface

`default_nettype wire

// File: rtl/oka_div_step.sv
// ============================================================================
//  oka_div_step : one quotient bit of y * b^-1 mod x^W (combinational)
//  Rev 1.0
// ============================================================================
`default_nettype none

module oka_div_step #(
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input  logic [W-1:0]     r_i,
  input  logic [W-1:0]     bq_i,
  input  logic [CNT_W-1:0] k_i,
  output logic [W-1:0]     r_o,
  output logic             qbit_o
);

  logic [W-1:0] w_shift;

  // Bits shifted past x^(W-1) fall off: the product is truncated mod x^W.
  assign w_shift = bq_i << k_i;
  assign qbit_o  = r_i[k_i];
  assign r_o     = qbit_o ? (r_i ^ w_shift) : r_i;

endmodule

`default_nettype wire

// File: rtl/oka_trunc_div.sv
// ============================================================================
//  oka_trunc_div : bit-serial inverse of the truncated carry-less multiplier
//  Rev 1.0
// ============================================================================
`default_nettype none

module oka_trunc_div
  import oka_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  oka_trunc_div_if.slave   bus_io
);

  localparam int              CNT_WL = $clog2(W);
  localparam logic [CNT_WL-1:0] C_LAST = CNT_WL'(W - 1);

  state_e              state_q, state_d;
  logic [W-1:0]        r_q, r_d;
  logic [W-1:0]        bq_q, bq_d;
  logic [W-1:0]        a_q, a_d;
  logic                err_q, err_d;
  logic [CNT_WL-1:0]   cnt_q, cnt_d;

  logic [W-1:0]        w_step_r;
  logic                w_qbit;
  logic [W-1:0]        w_low_mask;

  oka_div_step #(
    .W     (W),
    .CNT_W (CNT_WL)
  ) u_step (
    .r_i    (r_q),
    .bq_i   (bq_q),
    .k_i    (cnt_q),
    .r_o    (w_step_r),
    .qbit_o (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      bq_q    <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      bq_q    <= bq_d;
      a_q     <= a_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    bq_d    = bq_q;
    a_d     = a_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          r_d   = bus_io.y;
          bq_d  = bus_io.b;
          a_d   = '0;
          cnt_d = '0;
          // An even divisor has no inverse mod x^W.
          if (bus_io.b[0]) begin
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        a_d[cnt_q] = w_qbit;
        r_d        = w_step_r;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == C_LAST) state_d = DONE;
      end
      DONE: begin
        if (bus_io.out_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.in_ready  = (state_q == IDLE);
  assign bus_io.out_valid = (state_q == DONE);
  assign bus_io.a         = a_q;
  assign bus_io.err       = err_q;

  // Low k+1 remainder bits are cleared once step k has been applied.
  assign w_low_mask = (W'(2) << cnt_q) - W'(1);

  a_low_clear: assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN) |-> ((w_step_r & w_low_mask) == '0));

endmodule

`default_nettype wire
